// File: rtl/queue_scheduler.sv
// Ticket-queue scheduler: counts waiting customers and calls them, one at a time,
// to tellers that signal ready, round-robin over the open tellers.
module queue_scheduler #(
  parameter int MAXQ      = 7,
  parameter int ALARM_LVL = 6,
  parameter int CALL_GAP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arrive,
  input  logic [2:0] done,
  input  logic [1:0] tcount,
  output logic [3:0] count,
  output logic [3:0] ticket,
  output logic [3:0] serve_ticket,
  output logic [1:0] serve_teller,
  output logic       call,
  output logic       full_flag,
  output logic       empty_flag,
  output logic       alarm
);

  localparam int HW = (CALL_GAP > 1) ? $clog2(CALL_GAP) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]    r_state;
  logic [HW-1:0] r_hold;
  logic          r_live;
  logic          r_arrive_d;
  logic [2:0]    r_done_d;
  logic [2:0]    r_req;
  logic [1:0]    r_last_grant;
  logic [3:0]    r_count, r_ticket, r_head, r_serve_ticket;
  logic [1:0]    r_serve_teller;

  logic [2:0] w_en, w_done_edge, w_elig, w_gmask, w_req_nxt;
  logic [1:0] w_start, w_c1, w_c2, w_gsel;
  logic       w_arr_edge, w_grant, w_accept;

  // r_live masks the first edge after reset so inputs held high through reset
  // must fall and rise again before they count.
  assign w_arr_edge = r_live & arrive & ~r_arrive_d;

  generate
    for (genvar i = 0; i < 3; i++) begin : g_teller
      assign w_en[i]        = (tcount > 2'(i));
      assign w_done_edge[i] = r_live & done[i] & ~r_done_d[i];
      assign w_gmask[i]     = w_grant && (w_gsel == 2'(i));
      assign w_req_nxt[i]   = ((r_req[i] & ~w_gmask[i]) | w_done_edge[i]) & w_en[i];
    end
  endgenerate

  assign w_elig  = r_req & w_en;
  assign w_start = (r_last_grant == 2'd2) ? 2'd0 : r_last_grant + 2'd1;
  assign w_c1    = (w_start == 2'd2) ? 2'd0 : w_start + 2'd1;
  assign w_c2    = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;

  always_comb begin
    w_gsel = w_c2;
    if (w_elig[w_start])   w_gsel = w_start;
    else if (w_elig[w_c1]) w_gsel = w_c1;
  end

  // Grant uses registered count only; a same-edge arrival cannot enable it.
  assign w_grant  = (r_state == S_IDLE) && (r_count != 4'd0) && (|w_elig);
  assign w_accept = w_arr_edge && ((r_count < 4'(MAXQ)) || w_grant);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_hold         <= '0;
      r_live         <= 1'b0;
      r_arrive_d     <= 1'b0;
      r_done_d       <= 3'b000;
      r_req          <= 3'b000;
      r_last_grant   <= 2'd2;
      r_count        <= 4'd0;
      r_ticket       <= 4'd0;
      r_head         <= 4'd0;
      r_serve_ticket <= 4'd0;
      r_serve_teller <= 2'd3;
    end else begin
      r_live     <= 1'b1;
      r_arrive_d <= arrive;
      r_done_d   <= done;
      r_req      <= w_req_nxt;
      if (w_accept) r_ticket <= r_ticket + 4'd1;
      if (w_accept && !w_grant)      r_count <= r_count + 4'd1;
      else if (w_grant && !w_accept) r_count <= r_count - 4'd1;
      if (w_grant) begin
        r_head         <= r_head + 4'd1;
        r_serve_ticket <= r_head;
        r_serve_teller <= w_gsel;
        r_last_grant   <= w_gsel;
      end
      case (r_state)
        S_IDLE:  if (w_grant) r_state <= S_GRANT;
        S_GRANT: begin
          r_state <= S_HOLD;
          r_hold  <= HW'(CALL_GAP - 1);
        end
        S_HOLD: begin
          if (r_hold == '0) r_state <= S_IDLE;
          else              r_hold  <= r_hold - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign count        = r_count;
  assign ticket       = r_ticket;
  assign serve_ticket = r_serve_ticket;
  assign serve_teller = r_serve_teller;
  assign call         = (r_state == S_GRANT);
  assign full_flag    = (r_count == 4'(MAXQ));
  assign empty_flag   = (r_count == 4'd0);
  assign alarm        = (r_count >= 4'(ALARM_LVL));

endmodule

// File: tb/tb_queue_scheduler.sv
// Directed bench for queue_scheduler; expected calls are queued when stimulus is
// driven and matched against each call pulse.
module tb_queue_scheduler;

  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       arrive;
  logic [2:0] done;
  logic [1:0] tcount;
  logic [3:0] count, ticket, serve_ticket;
  logic [1:0] serve_teller;
  logic       call, full_flag, empty_flag, alarm;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct packed {
    logic [1:0] tel;
    logic [3:0] tkt;
  } call_t;
  call_t sb[$];

  queue_scheduler #(.MAXQ(7), .ALARM_LVL(6), .CALL_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .arrive(arrive), .done(done), .tcount(tcount),
    .count(count), .ticket(ticket), .serve_ticket(serve_ticket),
    .serve_teller(serve_teller), .call(call), .full_flag(full_flag),
    .empty_flag(empty_flag), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    reset = 1'b0; arrive = 1'b0; done = 3'b000;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic arrive_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      arrive = 1'b1; tick();
      arrive = 1'b0; tick();
    end
  endtask

  task automatic done_pulse(input logic [2:0] m);
    done = m; tick();
    done = 3'b000;
  endtask

  task automatic wait_call(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (call) break;
      tick();
    end
    chk("call_seen", {31'd0, call}, 1);
  endtask

  task automatic expect_call(input logic [1:0] tel, input logic [3:0] tkt);
    call_t e;
    e.tel = tel;
    e.tkt = tkt;
    sb.push_back(e);
  endtask

  // Every call pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    call_t e;
    if (call) begin
      if (sb.size() == 0) chk("spurious_call", {31'd0, call}, 0);
      else begin
        e = sb.pop_front();
        chk("mon_serve_teller", {30'd0, serve_teller}, {30'd0, e.tel});
        chk("mon_serve_ticket", {28'd0, serve_ticket}, {28'd0, e.tkt});
      end
    end
  end

  initial begin : stim
    int times[$];
    tcount = 2'd1;

    // reset values
    reset_dut();
    reset = 1'b0; tick();
    chk("rst_count", count, 0);
    chk("rst_ticket", ticket, 0);
    chk("rst_serve_teller", serve_teller, 3);
    chk("rst_serve_ticket", serve_ticket, 0);
    chk("rst_call", call, 0);
    chk("rst_empty", empty_flag, 1);
    chk("rst_full", full_flag, 0);
    chk("rst_alarm", alarm, 0);
    reset = 1'b1; tick();

    // single teller, three customers, one call
    reset_dut(); tcount = 2'd1;
    arrive_pulse(3);
    chk("s1_count", count, 3);
    chk("s1_ticket", ticket, 3);
    chk("s1_empty", empty_flag, 0);
    expect_call(2'd0, 4'd0);
    done_pulse(3'b001);
    chk("s1_latency", call, 0);
    wait_call(10);
    chk("s1_count_after", count, 2);
    repeat (8) tick();

    // fill to capacity, drop the overflow
    reset_dut(); tcount = 2'd1;
    arrive_pulse(6);
    chk("s2_alarm6", alarm, 1);
    chk("s2_full6", full_flag, 0);
    arrive_pulse(1);
    chk("s2_count7", count, 7);
    chk("s2_full7", full_flag, 1);
    arrive_pulse(1);
    chk("s2_count_drop", count, 7);
    chk("s2_ticket_drop", ticket, 7);
    chk("s2_alarm", alarm, 1);

    // three tellers ready together: round-robin 0,1,2 spaced by the hold gap
    reset_dut(); tcount = 2'd3;
    arrive_pulse(5);
    expect_call(2'd0, 4'd0);
    expect_call(2'd1, 4'd1);
    expect_call(2'd2, 4'd2);
    done_pulse(3'b111);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (call) times.push_back(cyc);
    end
    chk("s3_ncalls", times.size(), 3);
    if (times.size() == 3) begin
      chk("s3_gap01", times[1] - times[0], GAP + 2);
      chk("s3_gap12", times[2] - times[1], GAP + 2);
    end
    chk("s3_count", count, 2);

    // ready teller waits for a customer; same-edge arrival cannot grant
    reset_dut(); tcount = 2'd2;
    done_pulse(3'b010);
    repeat (10) tick();
    chk("s4_count0", count, 0);
    expect_call(2'd1, 4'd0);
    arrive = 1'b1; tick();
    chk("s4_no_same_edge_grant", call, 0);
    arrive = 1'b0; tick();
    chk("s4_call", call, 1);
    chk("s4_teller", serve_teller, 1);
    repeat (8) tick();

    // arrival coincides with a grant while full
    reset_dut(); tcount = 2'd1;
    arrive_pulse(7);
    chk("s5_full", count, 7);
    expect_call(2'd0, 4'd0);
    done = 3'b001; tick();
    done = 3'b000; arrive = 1'b1; tick();
    arrive = 1'b0;
    chk("s5_call", call, 1);
    chk("s5_count", count, 7);
    chk("s5_ticket", ticket, 8);
    chk("s5_head", 4'(ticket - count), 1);
    repeat (8) tick();

    // disabled teller ignored; reset aborts HOLD; held input gives no edge
    reset_dut(); tcount = 2'd1;
    arrive_pulse(2);
    done_pulse(3'b100);
    repeat (10) tick();
    chk("s6_ignored", count, 2);
    expect_call(2'd0, 4'd0);
    done_pulse(3'b001);
    wait_call(10);
    tick();
    reset = 1'b0; tick();
    chk("s6_count", count, 0);
    chk("s6_ticket", ticket, 0);
    chk("s6_serve_teller", serve_teller, 3);
    chk("s6_serve_ticket", serve_ticket, 0);
    chk("s6_call", call, 0);
    chk("s6_empty", empty_flag, 1);
    arrive = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("s6_held_arrive", count, 0);
    arrive = 1'b0; tick();
    arrive = 1'b1; tick();
    chk("s6_rearm", count, 1);
    arrive = 1'b0;
    repeat (3) tick();

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
